// File: rtl/mram_if.sv
// Parallel MRAM device bus: controller-driven strobes/address/data and
// responder-driven read data, status pulses and access counters.
interface mram_if #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  send_data;
    logic                  chip_en;
    logic                  write_en;
    logic                  out_en;
    logic                  lower_byte_en;
    logic                  upper_byte_en;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  busy;
    logic                  addr_err;
    logic                  proto_err;
    logic [15:0]           wr_count;
    logic [15:0]           rd_count;

    modport master (
        output addr, data_in, send_data, chip_en, write_en, out_en,
               lower_byte_en, upper_byte_en,
        input  data_out, data_valid, busy, addr_err, proto_err,
               wr_count, rd_count
    );

    modport slave (
        input  addr, data_in, send_data, chip_en, write_en, out_en,
               lower_byte_en, upper_byte_en,
        output data_out, data_valid, busy, addr_err, proto_err,
               wr_count, rd_count
    );
endinterface

// File: rtl/mram_responder.sv
// MRAM stand-in: edge-triggered strobe decode, byte-masked writes into a
// word array, and fixed-latency reads with error pulses and access counters.
module mram_responder #(
    parameter int ADDR_WIDTH   = 20,
    parameter int DATA_WIDTH   = 16,
    parameter int MEM_AW       = 8,
    parameter int READ_LATENCY = 1
) (
    input logic  clk,
    input logic  rst,
    mram_if.slave bus
);
    localparam int         DEPTH    = 2 ** MEM_AW;
    localparam int         HI_W     = ADDR_WIDTH - MEM_AW;
    localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY - 1);

    typedef enum logic [0:0] {IDLE = 1'b0, RD_WAIT = 1'b1} state_t;

    state_t                state_r, state_s;
    logic                  act_s, act_prev_r, start_s;
    logic                  oor_s, no_lane_s;
    logic                  wr_s, rd_start_s, rd_done_s, perr_s, aerr_s;
    logic [1:0]            lat_cnt_r;
    logic [MEM_AW-1:0]     rd_addr_r;
    logic                  rd_oor_r, rd_lo_r, rd_hi_r;
    logic [DATA_WIDTH-1:0] rd_word_s;
    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] data_out_r;
    logic                  data_valid_r, busy_r, addr_err_r, proto_err_r;
    logic [15:0]           wr_count_r, rd_count_r;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign act_s     = ~bus.chip_en & bus.send_data;
    assign start_s   = act_s & ~act_prev_r;
    assign oor_s     = bus.addr[ADDR_WIDTH-1:MEM_AW] != {HI_W{1'b0}};
    assign no_lane_s = bus.lower_byte_en & bus.upper_byte_en;

    // State, strobe edge history and latency counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= IDLE;
            act_prev_r <= 1'b0;
            lat_cnt_r  <= 2'd0;
        end else begin
            state_r    <= state_s;
            act_prev_r <= act_s;
            lat_cnt_r  <= (state_r == RD_WAIT && !rd_done_s) ? lat_cnt_r + 2'd1 : 2'd0;
        end
    end

    // Next-state selection.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = rd_start_s ? RD_WAIT : IDLE;
            RD_WAIT: state_s = rd_done_s ? IDLE : RD_WAIT;
            default: state_s = IDLE;
        endcase
    end

    // Command decode; write_en wins over out_en, starts during a read are rejected.
    always_comb begin
        wr_s       = 1'b0;
        rd_start_s = 1'b0;
        rd_done_s  = 1'b0;
        perr_s     = 1'b0;
        aerr_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    aerr_s = oor_s;
                    if (no_lane_s) begin
                        perr_s = 1'b1;
                    end else if (!bus.write_en) begin
                        wr_s   = 1'b1;
                        perr_s = ~bus.out_en;
                    end else if (!bus.out_en) begin
                        rd_start_s = 1'b1;
                    end else begin
                        perr_s = 1'b1;
                    end
                end else begin
                    aerr_s = 1'b0;
                end
            end
            RD_WAIT: begin
                rd_done_s = (lat_cnt_r == LAT_LAST);
                perr_s    = start_s;
            end
            default: begin
                perr_s = 1'b0;
            end
        endcase
    end

    // Lane-masked read word; disabled lanes and out-of-range reads return zero.
    always_comb begin
        rd_word_s = mem_r[rd_addr_r];
        if (rd_oor_r) begin
            rd_word_s = 16'h0000;
        end else begin
            rd_word_s[7:0]  = rd_lo_r ? rd_word_s[7:0]  : 8'h00;
            rd_word_s[15:8] = rd_hi_r ? rd_word_s[15:8] : 8'h00;
        end
    end

    // Byte-masked array write; the array deliberately has no reset.
    always_ff @(posedge clk) begin
        if (rst && wr_s && !oor_s) begin
            if (!bus.lower_byte_en) mem_r[bus.addr[MEM_AW-1:0]][7:0]  <= bus.data_in[7:0];
            if (!bus.upper_byte_en) mem_r[bus.addr[MEM_AW-1:0]][15:8] <= bus.data_in[15:8];
        end
    end

    // Read capture and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_addr_r    <= {MEM_AW{1'b0}};
            rd_oor_r     <= 1'b0;
            rd_lo_r      <= 1'b0;
            rd_hi_r      <= 1'b0;
            data_out_r   <= 16'h0000;
            data_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            addr_err_r   <= 1'b0;
            proto_err_r  <= 1'b0;
            wr_count_r   <= 16'h0000;
            rd_count_r   <= 16'h0000;
        end else begin
            if (rd_start_s) begin
                rd_addr_r <= bus.addr[MEM_AW-1:0];
                rd_oor_r  <= oor_s;
                rd_lo_r   <= ~bus.lower_byte_en;
                rd_hi_r   <= ~bus.upper_byte_en;
            end
            if (rd_done_s) data_out_r <= rd_word_s;
            if (wr_s) wr_count_r <= sat_inc(wr_count_r);
            if (rd_done_s) rd_count_r <= sat_inc(rd_count_r);
            data_valid_r <= rd_done_s;
            busy_r       <= (state_s == RD_WAIT);
            addr_err_r   <= aerr_s;
            proto_err_r  <= perr_s;
        end
    end

    assign bus.data_out   = data_out_r;
    assign bus.data_valid = data_valid_r;
    assign bus.busy       = busy_r;
    assign bus.addr_err   = addr_err_r;
    assign bus.proto_err  = proto_err_r;
    assign bus.wr_count   = wr_count_r;
    assign bus.rd_count   = rd_count_r;
endmodule

// File: tb/tb_mram_responder.sv
// Directed bench for mram_responder: vector table of single accesses plus
// hand-written busy-restart, reset-mid-read and counter saturation sequences.
module tb_mram_responder;
    localparam int RL = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    mram_if #(.ADDR_WIDTH(20), .DATA_WIDTH(16)) bus ();

    mram_responder #(.ADDR_WIDTH(20), .DATA_WIDTH(16), .MEM_AW(8), .READ_LATENCY(RL)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] a;
        logic [15:0] d;
        logic        we, oe, lbe, ube;
        int          hold;
        int          e_valid;
        logic [15:0] e_dout;
        int          e_perr, e_aerr, e_busy;
        logic [15:0] e_wr, e_rd;
    } vec_t;

    function automatic vec_t mk(input logic [19:0] a, input logic [15:0] d,
                                input logic we, oe, lbe, ube, input int hold,
                                input int e_valid, input logic [15:0] e_dout,
                                input int e_perr, e_aerr,
                                input logic [15:0] e_wr, e_rd);
        vec_t v;
        v.a = a; v.d = d; v.we = we; v.oe = oe; v.lbe = lbe; v.ube = ube;
        v.hold = hold; v.e_valid = e_valid; v.e_dout = e_dout;
        v.e_perr = e_perr; v.e_aerr = e_aerr; v.e_busy = e_valid * RL;
        v.e_wr = e_wr; v.e_rd = e_rd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic idle_bus();
        bus.chip_en = 1'b1; bus.send_data = 1'b0; bus.write_en = 1'b1;
        bus.out_en = 1'b1; bus.lower_byte_en = 1'b1; bus.upper_byte_en = 1'b1;
    endtask

    // Strobe for 'hold' cycles starting at the next edge, then observe 6 edges.
    task automatic do_access(input logic [19:0] a, input logic [15:0] d,
                             input logic we, oe, lbe, ube, input int hold,
                             output int n_valid, output int valid_at,
                             output logic [15:0] dout, output int n_perr,
                             output int n_aerr, output int n_busy);
        n_valid = 0; valid_at = -1; n_perr = 0; n_aerr = 0; n_busy = 0;
        @(negedge clk);
        bus.addr = a; bus.data_in = d; bus.write_en = we; bus.out_en = oe;
        bus.lower_byte_en = lbe; bus.upper_byte_en = ube;
        bus.chip_en = 1'b0; bus.send_data = 1'b1;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            if (bus.data_valid) begin n_valid++; valid_at = j; end
            if (bus.proto_err) n_perr++;
            if (bus.addr_err) n_aerr++;
            if (bus.busy) n_busy++;
            if (j == hold - 1) idle_bus();
        end
        dout = bus.data_out;
    endtask

    vec_t vt[19];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          nv, va, np, na, nb;
        logic [15:0] dout;
        logic [15:0] wr_before;

        //        addr      data      we    oe    lbe   ube  hold v  dout      perr aerr wr     rd
        vt[0]  = mk(20'h00012, 16'hBEEF, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 16'h0000, 0, 0, 16'd1, 16'd0);
        vt[1]  = mk(20'h00012, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2, 1, 16'hBEEF, 0, 0, 16'd1, 16'd1);
        vt[2]  = mk(20'h00005, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 16'hBEEF, 0, 0, 16'd2, 16'd1);
        vt[3]  = mk(20'h00005, 16'hABCD, 1'b0, 1'b1, 1'b1, 1'b0, 1, 0, 16'hBEEF, 0, 0, 16'd3, 16'd1);
        vt[4]  = mk(20'h00005, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2, 1, 16'hAB34, 0, 0, 16'd3, 16'd2);
        vt[5]  = mk(20'h00005, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 2, 1, 16'h0034, 0, 0, 16'd3, 16'd3);
        vt[6]  = mk(20'h00007, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 16'h0034, 1, 0, 16'd4, 16'd3);
        vt[7]  = mk(20'h00007, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2, 1, 16'h5555, 0, 0, 16'd4, 16'd4);
        vt[8]  = mk(20'h00007, 16'h1111, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0, 16'h5555, 1, 0, 16'd4, 16'd4);
        vt[9]  = mk(20'h00007, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2, 1, 16'h5555, 0, 0, 16'd4, 16'd5);
        vt[10] = mk(20'h00007, 16'h2222, 1'b0, 1'b1, 1'b1, 1'b1, 1, 0, 16'h5555, 1, 0, 16'd4, 16'd5);
        vt[11] = mk(20'h00007, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 2, 0, 16'h5555, 1, 0, 16'd4, 16'd5);
        vt[12] = mk(20'h00007, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2, 1, 16'h5555, 0, 0, 16'd4, 16'd6);
        vt[13] = mk(20'h00003, 16'h7777, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 16'h5555, 0, 0, 16'd5, 16'd6);
        vt[14] = mk(20'h10003, 16'h9999, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 16'h5555, 0, 1, 16'd6, 16'd6);
        vt[15] = mk(20'h00003, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2, 1, 16'h7777, 0, 0, 16'd6, 16'd7);
        vt[16] = mk(20'h10003, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2, 1, 16'h0000, 0, 1, 16'd6, 16'd8);
        vt[17] = mk(20'h00003, 16'h4444, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 16'h0000, 0, 0, 16'd7, 16'd8);
        vt[18] = mk(20'h00020, 16'h0F0F, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 16'h0000, 0, 0, 16'd8, 16'd8);

        idle_bus();
        bus.addr = 20'h00000; bus.data_in = 16'h0000;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst data_out", 32'(bus.data_out), 32'h0);
        chk("rst data_valid", 32'(bus.data_valid), 32'h0);
        chk("rst busy", 32'(bus.busy), 32'h0);
        chk("rst addr_err", 32'(bus.addr_err), 32'h0);
        chk("rst proto_err", 32'(bus.proto_err), 32'h0);
        chk("rst wr_count", 32'(bus.wr_count), 32'h0);
        chk("rst rd_count", 32'(bus.rd_count), 32'h0);
        rst = 1'b1;

        for (int i = 0; i < 19; i++) begin
            do_access(vt[i].a, vt[i].d, vt[i].we, vt[i].oe, vt[i].lbe, vt[i].ube,
                      vt[i].hold, nv, va, dout, np, na, nb);
            chk($sformatf("v%0d valid_count", i), 32'(nv), 32'(vt[i].e_valid));
            chk($sformatf("v%0d valid_edge", i), 32'(va), vt[i].e_valid != 0 ? 32'(RL) : 32'hFFFFFFFF);
            chk($sformatf("v%0d data_out", i), 32'(dout), 32'(vt[i].e_dout));
            chk($sformatf("v%0d proto_err", i), 32'(np), 32'(vt[i].e_perr));
            chk($sformatf("v%0d addr_err", i), 32'(na), 32'(vt[i].e_aerr));
            chk($sformatf("v%0d busy_cycles", i), 32'(nb), 32'(vt[i].e_busy));
            chk($sformatf("v%0d wr_count", i), 32'(bus.wr_count), 32'(vt[i].e_wr));
            chk($sformatf("v%0d rd_count", i), 32'(bus.rd_count), 32'(vt[i].e_rd));
        end

        // A new start while a read is in latency is rejected; the read completes.
        wr_before = bus.wr_count;
        @(negedge clk);
        bus.addr = 20'h00020; bus.write_en = 1'b1; bus.out_en = 1'b0;
        bus.lower_byte_en = 1'b0; bus.upper_byte_en = 1'b0;
        bus.chip_en = 1'b0; bus.send_data = 1'b1;
        @(negedge clk);
        chk("busy_rst busy e0", 32'(bus.busy), 32'h1);
        bus.chip_en = 1'b1; bus.send_data = 1'b0;
        @(negedge clk);
        chk("busy_rst busy e1", 32'(bus.busy), 32'h1);
        chk("busy_rst valid e1", 32'(bus.data_valid), 32'h0);
        bus.data_in = 16'hFFFF; bus.write_en = 1'b0; bus.out_en = 1'b1;
        bus.chip_en = 1'b0; bus.send_data = 1'b1;
        @(negedge clk);
        chk("busy_rst valid e2", 32'(bus.data_valid), 32'h1);
        chk("busy_rst data e2", 32'(bus.data_out), 32'h0F0F);
        chk("busy_rst proto_err", 32'(bus.proto_err), 32'h1);
        chk("busy_rst busy e2", 32'(bus.busy), 32'h0);
        idle_bus();
        @(negedge clk);
        chk("busy_rst wr_count", 32'(bus.wr_count), 32'(wr_before));
        do_access(20'h00020, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2, nv, va, dout, np, na, nb);
        chk("busy_rst mem kept", 32'(dout), 32'h0F0F);

        // Reset during read latency aborts the read but keeps the array.
        @(negedge clk);
        bus.addr = 20'h00012; bus.write_en = 1'b1; bus.out_en = 1'b0;
        bus.lower_byte_en = 1'b0; bus.upper_byte_en = 1'b0;
        bus.chip_en = 1'b0; bus.send_data = 1'b1;
        @(negedge clk);
        chk("midrst busy before", 32'(bus.busy), 32'h1);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst busy", 32'(bus.busy), 32'h0);
        chk("midrst valid", 32'(bus.data_valid), 32'h0);
        chk("midrst data_out", 32'(bus.data_out), 32'h0);
        chk("midrst wr_count", 32'(bus.wr_count), 32'h0);
        chk("midrst rd_count", 32'(bus.rd_count), 32'h0);
        rst = 1'b1;
        idle_bus();
        nv = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.data_valid) nv++;
        end
        chk("midrst no late valid", 32'(nv), 32'h0);
        do_access(20'h00012, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2, nv, va, dout, np, na, nb);
        chk("midrst mem kept", 32'(dout), 32'hBEEF);
        chk("midrst rd after", 32'(bus.rd_count), 32'h1);

        // Write counter saturation.
        @(negedge clk);
        force dut.wr_count_r = 16'hFFFE;
        @(negedge clk);
        release dut.wr_count_r;
        @(negedge clk);
        chk("sat preset", 32'(bus.wr_count), 32'hFFFE);
        do_access(20'h00030, 16'h1111, 1'b0, 1'b1, 1'b0, 1'b0, 1, nv, va, dout, np, na, nb);
        chk("sat reach max", 32'(bus.wr_count), 32'hFFFF);
        do_access(20'h00030, 16'h2222, 1'b0, 1'b1, 1'b0, 1'b0, 1, nv, va, dout, np, na, nb);
        chk("sat hold max", 32'(bus.wr_count), 32'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mram_responder.md
Name: mram_responder

Overview:
- Synthesizable MRAM-side responder: the device end of the parallel MRAM interface that the control/STP path drives.
- Samples the parallel address and data from the STP shift registers, decodes the active-low chip_en/write_en/out_en/byte-enable strobes, and performs byte-masked writes to an internal word array.
- Returns read data on a parallel bus for the PTS loader.
- Used on-FPGA as the MRAM stand-in for bring-up and regression before the physical part is attached.

Parameters:
- ADDR_WIDTH, 20, external address bus width.
- DATA_WIDTH, 16, word width; must be 16 (two byte lanes).
- MEM_AW, 8, implemented address bits; depth = 2**MEM_AW words.
- READ_LATENCY, 1, cycles from read-access start to data_valid; legal range 1..3.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- addr  in  ADDR_WIDTH  parallel address from the addr STP.
- data_in  in  DATA_WIDTH  parallel write data from the data STP.
- send_data  in  1  access qualifier from the controller.
- chip_en  in  1  active low.
- write_en  in  1  active low.
- out_en  in  1  active low.
- lower_byte_en  in  1  active low, lane [7:0].
- upper_byte_en  in  1  active low, lane [15:8].
- data_out  out  DATA_WIDTH  read data to the PTS load path.
- data_valid  out  1  one-cycle pulse when data_out is updated by a read.
- busy  out  1  high while a read is in latency.
- addr_err  out  1  one-cycle pulse on an access with addr[ADDR_WIDTH-1:MEM_AW] != 0.
- proto_err  out  1  one-cycle pulse on an illegal strobe combination.
- wr_count  out  16  saturating count of committed writes.
- rd_count  out  16  saturating count of completed reads.

Behaviour:
- Reset (rst=0 at clk edge):
  - All outputs go to 0 and the state goes to IDLE.
  - The internal edge register clears.
  - The memory array is not cleared.
  - A reset mid-read aborts the read with no data_valid.
- Access detection:
  - act = ~chip_en & send_data.
  - An access starts only on the cycle where act=1 and act was 0 on the previous cycle (rising edge).
  - Held strobes (the controller holds read strobes for 2 cycles) never retrigger.
- Command decode, evaluated at the start cycle:
  - write_en=0: WRITE. write_en=0 takes priority over out_en=0; if both are low, perform the write and pulse proto_err.
  - write_en=1, out_en=0: READ.
  - write_en=1, out_en=1: no-op; pulse proto_err.
  - Both byte enables high: no-op; pulse proto_err.
- WRITE:
  - Committed in the start cycle, with no latency.
  - Lane [7:0] is written from data_in[7:0] iff lower_byte_en=0; lane [15:8] from data_in[15:8] iff upper_byte_en=0.
  - wr_count increments.
  - FSM remains IDLE.
- READ (FSM IDLE -> RD_WAIT -> IDLE):
  - addr and byte enables are captured at the start cycle.
  - busy=1 for READ_LATENCY cycles. After READ_LATENCY clock edges, data_out is loaded and data_valid pulses for 1 cycle, while busy returns to 0.
  - For READ_LATENCY=1, data_out and data_valid update on the edge after the start cycle.
  - Disabled lanes read as 8'h00.
  - rd_count increments.
  - data_out holds its value until the next read completes; writes do not change it.
- Out of range:
  - Writes are discarded and reads return 16'h0000.
  - addr_err pulses in the start cycle.
  - The counters still increment.
- Starts while busy=1 are ignored, with proto_err pulsed; the in-flight read completes unchanged.
- A write followed by a read of the same address in the next start returns the newly written data (no stale read).
- The counters saturate at 16'hFFFF and do not wrap.

Test Plan:
- Full write then read: write addr=0x00012, data 0xBEEF, both lanes, 1-cycle strobe; then read the same address with 2-cycle strobes -> data_out=0xBEEF and data_valid high exactly 1 cycle, READ_LATENCY edges after the read start; wr_count=1, rd_count=1; no retrigger on the second strobe cycle.
- Byte masking: fill addr 0x05 with 0x1234; write 0xABCD with only upper_byte_en=0 -> full read gives 0xAB34; read with only lower_byte_en=0 -> 0x0034.
- Illegal strobes:
  - write_en=0 and out_en=0 at addr 0x07, data 0x5555 -> write commits and proto_err pulses.
  - write_en=1 and out_en=1 -> proto_err pulses and memory is unchanged.
  - Both byte enables high -> proto_err pulses and no counters change.
- Out of range: write addr=0x10003, data 0x9999 -> addr_err pulses; then read addr 0x00003 -> prior contents unchanged; read addr 0x10003 -> data_out=0x0000.
- Reset mid-read: start a read and assert rst=0 while busy=1 -> no data_valid; data_out, busy and both counters are 0; a subsequent read of a previously written address returns the stored word (memory preserved).
- Back-to-back and saturation: start a read during busy -> proto_err and the original data is returned; force wr_count to 0xFFFF and issue one more write -> wr_count stays 0xFFFF.
